// File: rtl/neocore_pkg.sv
// Shared NeoCore types: ALU operation encodings and the divider FSM states.
package neocore_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_DIV  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_DIVIDE = 2'd1,
        DIV_DONE   = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Unsigned multi-cycle restoring divider: one shift-subtract step per cycle,
// result laid out as {remainder, quotient} like the ALU result bus.
module div_unit
    import neocore_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 z_flag,
    output logic                 v_flag
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e         state_r;
    div_state_e         state_next_s;

    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH:0]     rem_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [2*WIDTH-1:0] result_r;
    logic               z_flag_r;
    logic               v_flag_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               div_zero_s;
    logic               last_step_s;
    logic [WIDTH+1:0]   rem_shift_s;
    logic [WIDTH+1:0]   diff_s;
    logic               q_bit_s;
    logic [WIDTH:0]     rem_next_s;
    logic [WIDTH-1:0]   quot_next_s;

    // Handshake decode: start only counts outside DIVIDE.
    always_comb begin
        accept_s    = start && ((state_r == DIV_IDLE) || (state_r == DIV_DONE));
        div_zero_s  = (divisor == {WIDTH{1'b0}});
        last_step_s = (state_r == DIV_DIVIDE) && (cnt_r == CNT_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start) begin
                    state_next_s = div_zero_s ? DIV_DONE : DIV_DIVIDE;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_DIVIDE: begin
                if (last_step_s) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_DIVIDE;
                end
            end
            DIV_DONE: begin
                if (start) begin
                    state_next_s = div_zero_s ? DIV_DONE : DIV_DIVIDE;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            default: state_next_s = DIV_IDLE;
        endcase
    end

    // One restoring step; the remainder stays below the divisor, so bit WIDTH+1
    // of the shifted value is always zero and diff_s[WIDTH+1] is a clean borrow.
    always_comb begin
        rem_shift_s = {rem_r, quot_r[WIDTH-1]};
        diff_s      = rem_shift_s - {2'b00, divisor_r};
        q_bit_s     = ~diff_s[WIDTH+1];
        if (q_bit_s) begin
            rem_next_s = diff_s[WIDTH:0];
        end else begin
            rem_next_s = rem_shift_s[WIDTH:0];
        end
        quot_next_s = {quot_r[WIDTH-2:0], q_bit_s};
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DIV_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == DIV_DIVIDE);
            done_r  <= (state_next_s == DIV_DONE);
        end
    end

    // Working datapath and result capture; results only move on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_r    <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            rem_r     <= {(WIDTH+1){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            result_r  <= {(2*WIDTH){1'b0}};
            z_flag_r  <= 1'b0;
            v_flag_r  <= 1'b0;
        end else if (accept_s) begin
            quot_r    <= dividend;
            divisor_r <= divisor;
            rem_r     <= {(WIDTH+1){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            if (div_zero_s) begin
                result_r <= {dividend, {WIDTH{1'b1}}};
                z_flag_r <= 1'b0;
                v_flag_r <= 1'b1;
            end
        end else if (state_r == DIV_DIVIDE) begin
            quot_r <= quot_next_s;
            rem_r  <= rem_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
            if (last_step_s) begin
                result_r <= {rem_next_s[WIDTH-1:0], quot_next_s};
                z_flag_r <= (quot_next_s == {WIDTH{1'b0}});
                v_flag_r <= 1'b0;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign z_flag = z_flag_r;
    assign v_flag = v_flag_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue time
// and popped when done is seen.
module tb_div_unit;

    localparam int WIDTH = 16;

    typedef struct {
        logic [2*WIDTH-1:0] res;
        logic               z;
        logic               v;
        int                 lat;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               z_flag;
    logic               v_flag;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .z_flag   (z_flag),
        .v_flag   (v_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model; latency is the index of the edge (after the accept edge)
    // on which the divider enters DONE. A zero divisor enters DONE on the accept
    // edge itself, so done is already high when the very next edge arrives.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == 16'h0000) begin
            e.res = {a, 16'hFFFF};
            e.z   = 1'b0;
            e.v   = 1'b1;
            e.lat = 0;
        end else begin
            e.res = {a % b, a / b};
            e.z   = ((a / b) == 16'h0000);
            e.v   = 1'b0;
            e.lat = WIDTH;
        end
        return e;
    endfunction

    // Call at a negedge; returns #1 after the accept edge with start dropped.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done, starting n0 edges after the accept edge; returns at the
    // negedge where done is high.
    task automatic wait_done(input string tag, input int n0);
        int   n       = n0;
        bit   seen    = 1'b0;
        bit   busy_ok = 1'b1;
        bit   excl_ok = 1'b1;
        exp_t e;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (busy && done) excl_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                @(posedge clk);
                n++;
            end
        end
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            if (!seen) begin
                check_val({tag, "_timeout"}, 64'd0, 64'd1);
            end else begin
                check_val({tag, "_latency"}, 64'(n), 64'(e.lat));
                check_val({tag, "_result"}, 64'(result), 64'(e.res));
                check_val({tag, "_z"}, 64'(z_flag), 64'(e.z));
                check_val({tag, "_v"}, 64'(v_flag), 64'(e.v));
                check_val({tag, "_busy_done_excl"}, 64'(excl_ok), 64'd1);
                if (e.lat != 0) check_val({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               pulsed;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'h0000;
        divisor  = 16'h0000;
        #12;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        check_val("rst_flags", 64'({z_flag, v_flag}), 64'd0);

        // Release reset and start on the very first edge afterwards.
        @(negedge clk);
        rst = 1'b0;
        issue(16'h0023, 16'h0007);
        wait_done("basic", 0);

        @(negedge clk); issue(16'h0014, 16'h0003); wait_done("rem", 0);
        @(negedge clk); issue(16'h0002, 16'h0005); wait_done("zero_q", 0);
        @(negedge clk); issue(16'h1234, 16'h0000); wait_done("div0", 0);
        @(negedge clk); issue(16'hFFFF, 16'h0001); wait_done("ffff_1", 0);
        @(negedge clk); issue(16'hFFFF, 16'hFFFF); wait_done("ffff_ffff", 0);
        @(negedge clk); issue(16'h8000, 16'h0002); wait_done("8000_2", 0);

        // New operands offered mid-division must be ignored.
        @(negedge clk);
        issue(16'h0023, 16'h0007);
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 16'h0001;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("start_busy", 6);

        // Reset mid-division: results cleared, no done for the dropped op.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'h00FF;
        divisor  = 16'h0003;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulsed = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done || busy) pulsed = 1'b1;
        end
        check_val("midrst_no_done", 64'(pulsed), 64'd0);
        check_val("midrst_result_held", 64'(result), 64'd0);

        // Back-to-back: start held while in DONE.
        @(negedge clk);
        issue(16'h0064, 16'h0009);
        wait_done("b2b_first", 0);
        issue(16'h0BEE, 16'h0011);
        wait_done("b2b_second", 0);

        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 300));
            @(negedge clk);
            issue(a, b);
            wait_done("random", 0);
        end

        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
